// File: rtl/conv_bin_layer.sv
// Streaming 3x3 binary convolution: two line delays plus a 3x3 window feed NUM_CH
// XNOR-popcount-threshold kernels, with one registered result per accepted pixel.
module conv_bin_layer #(
    parameter int WIDTH  = 28,
    parameter int HEIGHT = 28,
    parameter int NUM_CH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pixel_in,
    input  logic                  valid_in,
    input  logic                  sof_in,
    input  logic [NUM_CH*9-1:0]   weights,
    input  logic [NUM_CH*4-1:0]   thresh,
    output logic [NUM_CH-1:0]     conv_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic [CW-1:0]     col;
    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     row;
    logic [RW-1:0]     cur_row;
    logic [WIDTH-1:0]  line1;
    logic [WIDTH-1:0]  line2;
    logic [1:0]        top;
    logic [1:0]        mid;
    logic [1:0]        bot;
    logic [8:0]        window;
    logic              win_valid;
    logic              last_pix;
    logic [3:0]        match [NUM_CH];
    logic [NUM_CH-1:0] result;

    // sof_in on an accepted pixel forces its position to (0,0), resyncing the frame
    always_comb begin
        cur_col   = (sof_in) ? '0 : col;
        cur_row   = (sof_in) ? '0 : row;
        win_valid = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last_pix  = (cur_row == RW'(HEIGHT - 1)) && (cur_col == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (cur_col == CW'(WIDTH - 1)) begin
                col <= '0;
                row <= (cur_row == RW'(HEIGHT - 1)) ? '0 : RW'(cur_row + 1'b1);
            end else begin
                col <= CW'(cur_col + 1'b1);
                row <= cur_row;
            end
        end
    end

    // Buffer contents need no reset: outputs stay gated until two fresh rows are in
    always_ff @(posedge clk) begin
        if (valid_in) begin
            line1 <= {line1[WIDTH-2:0], pixel_in};
            line2 <= {line2[WIDTH-2:0], line1[WIDTH-1]};
            top   <= {top[0], line2[WIDTH-1]};
            mid   <= {mid[0], line1[WIDTH-1]};
            bot   <= {bot[0], pixel_in};
        end
    end

    // Bit k of the window is tap k: row-major, oldest row and leftmost column first
    assign window = {pixel_in, bot[0], bot[1],
                     line1[WIDTH-1], mid[0], mid[1],
                     line2[WIDTH-1], top[0], top[1]};

    always_comb begin
        result = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            match[c] = '0;
            for (int k = 0; k < 9; k++) begin
                match[c] = match[c] + {3'b000, ~(window[k] ^ weights[c*9+k])};
            end
            result[c] = (match[c] >= thresh[c*4 +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else if (valid_in) begin
            valid_out  <= win_valid;
            frame_done <= win_valid && last_pix;
            if (win_valid) begin
                conv_out <= result;
            end
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule
